// File: rtl/data_sram_resp_pkg.sv
// Shared constants, state encoding and helpers for the data SRAM responder.
package data_sram_resp_pkg;

  localparam int unsigned DefLatency = 2;
  localparam int unsigned DefAw      = 10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // An address is in range when every bit above the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/data_sram_resp_bytewrite_ram.sv
// Single-port synchronous RAM with per-byte write enables and a registered read port.
module bytewrite_ram #(
  parameter int unsigned AW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [3:0]    i_wen,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wen[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // The read register only loads on reads; writes leave it untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_en && (i_wen == 4'b0000)) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_resp.sv
// Memory-stage responder: latches a CPU request, stalls for LATENCY+1 cycles and
// performs one access on the byte-write RAM, flagging out-of-range addresses.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned LATENCY = DefLatency,
  parameter int unsigned AW      = DefAw
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        addr_err
);

  state_e        r_state, w_state_next;
  logic [3:0]    r_cnt, w_cnt_next;
  logic [3:0]    r_wen, w_wen_next;
  logic [AW-1:0] r_idx, w_idx_next;
  logic [31:0]   r_wdata, w_wdata_next;
  logic          r_oor, w_oor_next;
  logic          r_rd_zero, w_rd_zero_next;
  logic          w_access;
  logic          w_stall;
  logic          w_in_range;
  logic [31:0]   w_ram_rdata;

  assign w_in_range = addr_in_range(req_addr, AW);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_wen_next   = r_wen;
    w_idx_next   = r_idx;
    w_wdata_next = r_wdata;
    w_oor_next   = r_oor;
    w_access     = 1'b0;
    w_stall      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_en) begin
          w_stall      = 1'b1;
          w_wen_next   = req_wen;
          w_idx_next   = req_addr[AW+1:2];
          w_wdata_next = req_wdata;
          w_oor_next   = !w_in_range;
          w_cnt_next   = 4'(LATENCY);
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        w_stall = 1'b1;
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end
        if (r_cnt <= 4'd1) begin
          w_access     = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // An out-of-range read must present zero, independent of the RAM read register.
  assign w_rd_zero_next = w_access ? (r_oor && (r_wen == 4'b0000)) : r_rd_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_cnt     <= 4'd0;
      r_wen     <= 4'd0;
      r_idx     <= '0;
      r_wdata   <= 32'd0;
      r_oor     <= 1'b0;
      r_rd_zero <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_wen     <= w_wen_next;
      r_idx     <= w_idx_next;
      r_wdata   <= w_wdata_next;
      r_oor     <= w_oor_next;
      r_rd_zero <= w_rd_zero_next;
    end
  end

  bytewrite_ram #(
    .AW(AW)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_en    (w_access && !r_oor),
    .i_wen   (r_wen),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Gate with reset so a held req_en cannot raise stall while in reset.
  assign stall    = w_stall && rst;
  assign rdata    = r_rd_zero ? 32'd0 : w_ram_rdata;
  assign addr_err = (r_state == StDone) && r_oor;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: LATENCY=2 instance for most scenarios, LATENCY=1
// instance for the back-to-back stall pattern.
module tb_data_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req_en, b_req_en;
  logic [3:0]  a_req_wen, b_req_wen;
  logic [31:0] a_req_addr, b_req_addr, a_req_wdata, b_req_wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_stall, b_stall, a_addr_err, b_addr_err;

  int checks   = 0;
  int failures = 0;

  data_sram_resp #(
    .LATENCY(2),
    .AW     (10)
  ) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .req_en   (a_req_en),
    .req_wen  (a_req_wen),
    .req_addr (a_req_addr),
    .req_wdata(a_req_wdata),
    .rdata    (a_rdata),
    .stall    (a_stall),
    .addr_err (a_addr_err)
  );

  data_sram_resp #(
    .LATENCY(1),
    .AW     (10)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .req_en   (b_req_en),
    .req_wen  (b_req_wen),
    .req_addr (b_req_addr),
    .req_wdata(b_req_wdata),
    .rdata    (b_rdata),
    .stall    (b_stall),
    .addr_err (b_addr_err)
  );

  // One access on the LATENCY=2 instance; inputs are scrambled while it is busy.
  task automatic access_a(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] alt_addr,
                          input logic [31:0] alt_wdata, output logic [31:0] rd,
                          output logic err, output int stalls);
    bit done;
    stalls = 0;
    rd     = 32'd0;
    err    = 1'b0;
    done   = 1'b0;
    @(negedge clk);
    a_req_en    = 1'b1;
    a_req_wen   = wen;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    #1;
    if (a_stall) stalls++;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      a_req_en    = 1'b0;
      a_req_wen   = 4'hF;
      a_req_addr  = alt_addr;
      a_req_wdata = alt_wdata;
      #1;
      if (a_stall) stalls++;
      else begin
        rd   = a_rdata;
        err  = a_addr_err;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL access_timeout addr=%h stall never dropped", addr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_req_en = 1'b1; a_req_wen = 4'h0; a_req_addr = 32'h10; a_req_wdata = 32'h0;
    b_req_en = 1'b0; b_req_wen = 4'h0; b_req_addr = 32'h0;  b_req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (a_stall !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", a_stall);
    end
    checks++;
    if (a_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=00000000", a_rdata);
    end
    checks++;
    if (a_addr_err !== 1'b0) begin
      failures++; $display("FAIL reset_addr_err got=%b exp=0", a_addr_err);
    end
    @(negedge clk);
    a_req_en = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic err; int st;
    access_a(4'hF, 32'h10, 32'hDEADBEEF, 32'h10, 32'h0, rd, err, st);
    checks++;
    if (st !== 3) begin
      failures++; $display("FAIL wr_stall_cycles got=%0d exp=3", st);
    end
    access_a(4'h0, 32'h10, 32'h0, 32'h10, 32'h0, rd, err, st);
    checks++;
    if (st !== 3) begin
      failures++; $display("FAIL rd_stall_cycles got=%0d exp=3", st);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rd_data got=%h exp=deadbeef", rd);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL rd_addr_err got=%b exp=0", err);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] rd; logic err; int st;
    access_a(4'hF, 32'h20, 32'h11223344, 32'h20, 32'h0, rd, err, st);
    access_a(4'b0010, 32'h20, 32'hAAAAAAAA, 32'h20, 32'h0, rd, err, st);
    access_a(4'h0, 32'h20, 32'h0, 32'h20, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'h1122AA44) begin
      failures++; $display("FAIL byte_write got=%h exp=1122aa44", rd);
    end
    access_a(4'h0, 32'h23, 32'h0, 32'h23, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'h1122AA44) begin
      failures++; $display("FAIL low_bits_ignored got=%h exp=1122aa44", rd);
    end
  endtask

  task automatic test_busy_change();
    logic [31:0] rd; logic err; int st;
    access_a(4'hF, 32'h44, 32'h01020304, 32'h44, 32'h01020304, rd, err, st);
    access_a(4'hF, 32'h40, 32'h55667788, 32'h44, 32'hFFFFFFFF, rd, err, st);
    access_a(4'h0, 32'h40, 32'h0, 32'h40, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'h55667788) begin
      failures++; $display("FAIL busy_latched_wr got=%h exp=55667788", rd);
    end
    access_a(4'h0, 32'h44, 32'h0, 32'h44, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'h01020304) begin
      failures++; $display("FAIL busy_alt_untouched got=%h exp=01020304", rd);
    end
    // A read whose wen/addr are scrambled while busy must stay a read of 0x20.
    access_a(4'h0, 32'h20, 32'h0, 32'h10, 32'h77777777, rd, err, st);
    checks++;
    if (rd !== 32'h1122AA44) begin
      failures++; $display("FAIL busy_latched_rd got=%h exp=1122aa44", rd);
    end
    access_a(4'h0, 32'h10, 32'h0, 32'h10, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL busy_rd_no_write got=%h exp=deadbeef", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic err; int st;
    access_a(4'hF, 32'h0, 32'hCAFEF00D, 32'h0, 32'h0, rd, err, st);
    access_a(4'h0, 32'h00001000, 32'h0, 32'h0, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("FAIL oor_rd_data got=%h exp=00000000", rd);
    end
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL oor_rd_err got=%b exp=1", err);
    end
    @(negedge clk); #1;
    checks++;
    if (a_addr_err !== 1'b0) begin
      failures++; $display("FAIL oor_err_pulse got=%b exp=0", a_addr_err);
    end
    access_a(4'hF, 32'h00001010, 32'h0BADF00D, 32'h0, 32'h0, rd, err, st);
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL oor_wr_err got=%b exp=1", err);
    end
    access_a(4'h0, 32'h10, 32'h0, 32'h10, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL oor_wr_suppressed got=%h exp=deadbeef", rd);
    end
    access_a(4'h0, 32'h0, 32'h0, 32'h0, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      failures++; $display("FAIL oor_word0_intact got=%h exp=cafef00d", rd);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; logic err; int st;
    access_a(4'hF, 32'h30, 32'h13572468, 32'h30, 32'h0, rd, err, st);
    @(negedge clk);
    a_req_en = 1'b1; a_req_wen = 4'hF; a_req_addr = 32'h30; a_req_wdata = 32'h99999999;
    @(negedge clk);
    a_req_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (a_stall !== 1'b0) begin
      failures++; $display("FAIL midrst_stall got=%b exp=0", a_stall);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (a_stall !== 1'b0) begin
      failures++; $display("FAIL midrst_idle_stall got=%b exp=0", a_stall);
    end
    checks++;
    if (a_rdata !== 32'h0) begin
      failures++; $display("FAIL midrst_rdata got=%h exp=00000000", a_rdata);
    end
    access_a(4'h0, 32'h30, 32'h0, 32'h30, 32'h0, rd, err, st);
    checks++;
    if (rd !== 32'h13572468) begin
      failures++; $display("FAIL midrst_no_write got=%h exp=13572468", rd);
    end
    checks++;
    if (st !== 3) begin
      failures++; $display("FAIL midrst_first_req got=%0d exp=3", st);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  t_wen   [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
    logic [31:0] t_addr  [4] = '{32'h8, 32'hC, 32'h8, 32'hC};
    logic [31:0] t_wdata [4] = '{32'hA5A50001, 32'h5A5A0002, 32'h0, 32'h0};
    logic        exp_stall;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k % 3 == 0) begin
        b_req_wen   = t_wen[k/3];
        b_req_addr  = t_addr[k/3];
        b_req_wdata = t_wdata[k/3];
      end
      b_req_en = 1'b1;
      #1;
      exp_stall = (k % 3 != 2);
      checks++;
      if (b_stall !== exp_stall) begin
        failures++; $display("FAIL b2b_stall cycle=%0d got=%b exp=%b", k, b_stall, exp_stall);
      end
      if (k == 8) begin
        checks++;
        if (b_rdata !== 32'hA5A50001) begin
          failures++; $display("FAIL b2b_rd0 got=%h exp=a5a50001", b_rdata);
        end
      end
      if (k == 11) begin
        checks++;
        if (b_rdata !== 32'h5A5A0002) begin
          failures++; $display("FAIL b2b_rd1 got=%h exp=5a5a0002", b_rdata);
        end
      end
    end
    @(negedge clk);
    b_req_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_busy_change();
    test_out_of_range();
    test_reset_mid_write();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, number of BUSY cycles per access (legal range 1..15).
REQ-002 SHALL have parameter AW, default 10, log2 of word depth of the backing RAM.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_en  input  1  CPU memory-stage access request.
REQ-006 SHALL have port req_wen  input  4  byte write enables; 0000 means read.
REQ-007 SHALL have port req_addr  input  32  byte address; bits [AW+1:2] index the word.
REQ-008 SHALL have port req_wdata  input  32  write data, already byte-replicated by the CPU.
REQ-009 SHALL have port rdata  output  32  read data, valid only in the DONE cycle.
REQ-010 SHALL have port stall  output  1  hold-ME-stage request to the CPU hazard unit.
REQ-011 SHALL have port addr_err  output  1  pulse in DONE when the address is outside RAM range.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE & req_en: stall=1 combinationally, latch wen/addr/wdata, load cnt=LATENCY, go to BUSY.
REQ-014 IDLE & ~req_en: stall=0, stay in IDLE.
REQ-015 BUSY: stall=1; cnt decrements each cycle; when cnt==1, perform the access and go to DONE.
REQ-016 Access on a read: rdata register loads the RAM word.
REQ-017 Access on a write: only bytes with wen[i]=1 are updated (byte i = bits 8i+7:8i); rdata is unchanged.
REQ-018 DONE: stall=0; rdata holds the result; always return to IDLE, even if req_en is still high.
REQ-019 Total stall = LATENCY+1 cycles per access; the CPU advances in the DONE cycle.
REQ-020 Request inputs SHALL be ignored in BUSY and DONE; only the values latched in IDLE are used.
REQ-021 Back-to-back requests: a new req_en seen in the IDLE cycle after DONE starts a new access; there are no dead cycles beyond that IDLE.
REQ-022 Out-of-range address (req_addr[31:AW+2] != 0): a write is suppressed; a read returns 32'h0; addr_err=1 for the DONE cycle only.
REQ-023 Low address bits [1:0] SHALL be ignored; alignment checking belongs to the CPU.
REQ-024 cnt SHALL be 4 bits and never wrap: it reloads only in IDLE.

Reset
REQ-025 While rst=0: state=IDLE, stall=0, rdata=0, addr_err=0, cnt=0, latched request cleared.
REQ-026 Reset asserted mid-BUSY SHALL abort the access: no RAM write occurs, and the FSM is in IDLE on deassertion.
REQ-027 RAM contents SHALL NOT be reset.
REQ-028 The first request after reset deassertion SHALL be accepted normally.

Structure
REQ-029 State encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the default LATENCY/AW constants SHALL live in the shared defines header.
REQ-030 The RAM SHALL be a separate sub-module bytewrite_ram: synchronous, single port, 4 byte enables, registered read.
REQ-031 data_sram_resp SHALL contain only the FSM, the counter, the request latch and range checking.

Verification
REQ-032 Write then read: write addr 0x10, wen 1111, data 0xDEADBEEF; then read 0x10 -> stall high 3 cycles each (LATENCY=2), rdata=0xDEADBEEF in DONE.
REQ-033 Byte write: preload 0x11223344 at 0x20; write wen 0010, wdata 0xAAAAAAAA; read 0x20 -> 0x1122AA44.
REQ-034 Input change while busy: change req_addr/req_wdata during BUSY -> the originally latched values are used; RAM at the new address is unchanged.
REQ-035 Out of range (AW=10): read 0x00001000 -> rdata=0, addr_err=1 for one cycle; a write there leaves all RAM words unchanged.
REQ-036 Reset mid-write: assert rst low during BUSY of a write to 0x30 -> after release, a read of 0x30 returns the old value, and stall=0 while idle.
REQ-037 Back-to-back reads with LATENCY=1, req_en held high across two requests -> stall pattern 1,1,0 / 1,1,0 with no extra gap cycles.
